leb128_decoder_u32: RTL and testbench

//  Streaming unsigned LEB128 decoder. Accepts one byte per cycle on a valid/ready

---
 rtl/leb128_pkg.sv | 29 ++
 rtl/leb128_decoder_u32_merge.sv | 40 ++++
 rtl/leb128_decoder_u32.sv | 123 ++++++++++++
 tb/tb_leb128_decoder_u32.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/leb128_pkg.sv
// Shared LEB128 definitions.
// Holds the encoding constants, the decoder state type and a length helper
// that returns how many bytes the unsigned LEB128 encoding of a 32-bit value
// occupies (used by the packer and by verification).
package leb128_pkg;

  localparam int LEB_CONT_BIT      = 7;
  localparam int LEB_PAYLOAD_W     = 7;
  localparam int LEB_U32_MAX_BYTES = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SKIP = 2'd2,
    EMIT = 2'd3
  } leb_state_e;

  // Number of bytes in the minimal unsigned LEB128 encoding of value.
  function automatic logic [2:0] leb128_u32_len(input logic [31:0] value);
    logic [2:0] len;
    if (value < 32'h0000_0080)      len = 3'd1;
    else if (value < 32'h0000_4000) len = 3'd2;
    else if (value < 32'h0020_0000) len = 3'd3;
    else if (value < 32'h1000_0000) len = 3'd4;
    else                            len = 3'd5;
    return len;
  endfunction

endpackage

// File: rtl/leb128_decoder_u32_merge.sv
// Combinational payload merge for the u32 LEB128 decoder.
// Ports:
//   acc_i  [31:0] current accumulator
//   byte_i [7:0]  incoming encoded byte (bit 7 is ignored here)
//   cnt_i  [2:0]  number of bytes already merged (selects the 7-bit slot)
//   acc_o  [31:0] accumulator with this byte's payload ORed in
//   ovf_o         payload bits that do not fit in 32 bits were nonzero
module leb128_merge
  import leb128_pkg::*;
(
  input  logic [31:0] acc_i,
  input  logic [7:0]  byte_i,
  input  logic [2:0]  cnt_i,
  output logic [31:0] acc_o,
  output logic        ovf_o
);

  logic [LEB_PAYLOAD_W-1:0] payload;

  assign payload = byte_i[LEB_PAYLOAD_W-1:0];

  always_comb begin
    acc_o = acc_i;
    ovf_o = 1'b0;
    case (cnt_i)
      3'd0: acc_o = acc_i | {25'b0, payload};
      3'd1: acc_o = acc_i | {18'b0, payload, 7'b0};
      3'd2: acc_o = acc_i | {11'b0, payload, 14'b0};
      3'd3: acc_o = acc_i | {4'b0, payload, 21'b0};
      // Fifth group: only 4 bits remain in a 32-bit value; anything above
      // them is an overflow but the truncated value is still kept.
      3'd4: begin
        acc_o = acc_i | {payload[3:0], 28'b0};
        ovf_o = |payload[6:4];
      end
      default: acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/leb128_decoder_u32.sv
// Streaming unsigned LEB128 decoder producing 32-bit values.
// One byte per cycle is accepted on the input handshake; the decoded value,
// its encoded byte count and an error flag are presented on the output
// handshake.
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1; the sender holds its payload stable while
// valid=1 and ready=0, and ready never depends combinationally on valid.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     byte input handshake, in_byte [7]=cont, [6:0]=payload
//   out_valid/out_ready   result handshake
//   out_data  [31:0]      decoded value (truncated to 32 bits on overflow)
//   out_len   [2:0]       bytes consumed, saturating at 5
//   out_err               overflow or overlong encoding
//   dbg_state_o           current FSM state
module leb128_decoder_u32
  import leb128_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BYTES = LEB_U32_MAX_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_len,
  output logic              out_err,
  output leb_state_e        dbg_state_o
);

  localparam logic [2:0] CNT_SAT  = 3'(MAX_BYTES);
  localparam logic [2:0] CNT_LAST = 3'(MAX_BYTES - 1);

  leb_state_e  state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [31:0] merge_acc;
  logic        merge_ovf;
  logic        accept;
  logic        cont;
  logic [2:0]  cnt_inc;

  leb128_merge u_merge (
    .acc_i  (acc_q),
    .byte_i (in_byte),
    .cnt_i  (cnt_q),
    .acc_o  (merge_acc),
    .ovf_o  (merge_ovf)
  );

  assign in_ready  = (state_q != EMIT);
  assign accept    = in_valid && in_ready;
  assign cont      = in_byte[LEB_CONT_BIT];
  assign cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 3'd1;

  assign out_valid   = (state_q == EMIT);
  assign out_data    = acc_q[DATA_W-1:0];
  assign out_len     = cnt_q;
  assign out_err     = err_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          acc_d = merge_acc;
          cnt_d = cnt_inc;
          err_d = err_q | merge_ovf;
          if (!cont) begin
            state_d = EMIT;
          end else if (cnt_q == CNT_LAST) begin
            // Continuation on the last legal byte: overlong encoding.
            err_d   = 1'b1;
            state_d = SKIP;
          end else begin
            state_d = ACC;
          end
        end
      end
      SKIP: begin
        // Drain the rest of the overlong encoding without touching acc.
        if (accept) begin
          cnt_d = cnt_inc;
          if (!cont) state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_leb128_decoder_u32.sv
module tb_leb128_decoder_u32;
  import leb128_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_byte = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_len;
  logic        out_err;
  leb_state_e  dbg_state;

  always #5 clk = ~clk;

  leb128_decoder_u32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_byte     (in_byte),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_len     (out_len),
    .out_err     (out_err),
    .dbg_state_o (dbg_state)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // ---------------- scoreboard ----------------
  logic [35:0] exp_q[$];  // {err, len, data}

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL in_ready_timeout: byte 0x%0h not accepted in 100 cycles", b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a result, compare it, then complete the handshake.
  task automatic take_result(input string name, input logic [31:0] d,
                             input logic [2:0] l, input logic e);
    int t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_valid"}, {35'b0, out_valid}, 36'd1);
    chk({name, "_data"},  {4'b0, out_data},   {4'b0, d});
    chk({name, "_len"},   {33'b0, out_len},   {33'b0, l});
    chk({name, "_err"},   {35'b0, out_err},   {35'b0, e});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [55:0] bytes;   // byte 0 in bits [7:0]
    int          nb;
    logic [31:0] exp_data;
    logic [2:0]  exp_len;
    logic        exp_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{"zero",      56'h00,             1, 32'd0,          3'd1, 1'b0};
    tbl[1] = '{"max1",      56'h7F,             1, 32'd127,        3'd1, 1'b0};
    tbl[2] = '{"two_byte",  56'h0180,           2, 32'd128,        3'd2, 1'b0};
    tbl[3] = '{"three",     56'h268EE5,         3, 32'd624485,     3'd3, 1'b0};
    tbl[4] = '{"u32max",    56'h0FFFFFFFFF,     5, 32'hFFFF_FFFF,  3'd5, 1'b0};
    tbl[5] = '{"ovf_1f",    56'h1FFFFFFFFF,     5, 32'hFFFF_FFFF,  3'd5, 1'b1};
    tbl[6] = '{"ovf_70",    56'h7080808080,     5, 32'h0000_0000,  3'd5, 1'b1};
    tbl[7] = '{"overlong",  56'h01808080808080, 7, 32'h0000_0000,  3'd5, 1'b1};

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {35'b0, out_valid}, 36'd0);
    chk("rst_out_data",  {4'b0, out_data},   36'd0);
    chk("rst_out_len",   {33'b0, out_len},   36'd0);
    chk("rst_out_err",   {35'b0, out_err},   36'd0);
    chk("rst_in_ready",  {35'b0, in_ready},  36'd1);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < tbl[i].nb; k++) begin
        send_byte(tbl[i].bytes[k*8 +: 8]);
        if (tbl[i].name == "overlong" && k == 4)
          chk("skip_state", {34'b0, dbg_state, in_ready}, {34'b0, SKIP, 1'b1});
        if (tbl[i].name == "overlong" && k == 5)
          chk("skip_in_ready", {35'b0, in_ready}, 36'd1);
      end
      // Latency: result valid at the first negedge after the last accept.
      chk({tbl[i].name, "_latency"}, {35'b0, out_valid}, 36'd1);
      take_result(tbl[i].name, tbl[i].exp_data, tbl[i].exp_len, tbl[i].exp_err);
      chk({tbl[i].name, "_single"}, {35'b0, out_valid}, 36'd0);
    end

    // ---------------- backpressure ----------------
    send_byte(8'h96);
    send_byte(8'h01);
    in_valid = 1'b1;
    in_byte  = 8'h05;
    for (int c = 0; c < 4; c++) begin
      chk("bp_hold", {out_valid, out_len, out_data}, {1'b1, 3'd2, 32'd150});
      chk("bp_in_ready", {35'b0, in_ready}, 36'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_released", {34'b0, out_valid, in_ready}, {34'b0, 1'b0, 1'b1});
    @(negedge clk);
    in_valid = 1'b0;
    take_result("bp_next", 32'd5, 3'd1, 1'b0);

    // ---------------- reset mid-value ----------------
    send_byte(8'hE5);
    send_byte(8'h8E);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_clear", {out_valid, out_len, out_data}, 36'd0);
    chk("midrst_in_ready", {35'b0, in_ready}, 36'd1);
    send_byte(8'h01);
    take_result("midrst_after", 32'd1, 3'd1, 1'b0);

    // ---------------- random stream vs scoreboard ----------------
    fork
      begin : drv
        for (int n = 0; n < 4000; n++) begin
          logic [31:0] v, r;
          int nb;
          v  = $urandom >> $urandom_range(0, 31);
          nb = 0;
          exp_q.push_back({1'b0, leb128_u32_len(v), v});
          r = v;
          do begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send_byte({(r >> 7) != 0, r[6:0]});
            r = r >> 7;
            nb++;
          end while (r != 0 && nb < 5);
        end
      end
      begin : mon
        int got = 0;
        int cyc = 0;
        while (got < 4000 && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_fail++;
              $display("FAIL rand_unexpected: result 0x%0h with empty queue", out_data);
            end else begin
              chk("rand_result", {out_err, out_len, out_data}, exp_q.pop_front());
            end
            got++;
          end
        end
        if (got < 4000) begin
          n_vec++;
          n_fail++;
          $display("FAIL rand_timeout: got %0d results expected 4000", got);
        end
        @(negedge clk);
        out_ready = 1'b0;
      end
    join
    chk("rand_queue_empty", 36'(exp_q.size()), 36'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
